// File: rtl/base_and_or_checker.sv
// Response checker for the base_and_or AND/OR unit: registers each stimulus/response
// sample, scores it one cycle later and tallies mismatches over a run of NUM_CHECKS samples.
module base_and_or_checker #(
    parameter int WIDTH      = 4,
    parameter int CNT_WIDTH  = 2,
    parameter int NUM_CHECKS = 3,
    parameter int IDX_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 chkValid,
    input  logic [WIDTH-1:0]     aIn,
    input  logic [WIDTH-1:0]     bIn,
    input  logic                 doAnd,
    input  logic                 doOr,
    input  logic                 isAnd,
    input  logic [WIDTH-1:0]     out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic                 mismatch,
    output logic [1:0]           mismatchKind,
    output logic [CNT_WIDTH-1:0] failedCount,
    output logic [IDX_WIDTH-1:0] checkCount
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic                   sampleValid_q, sampleValid_d;
    logic [WIDTH-1:0]       aIn_q, bIn_q, out_q;
    logic                   doAnd_q, doOr_q, isAnd_q;
    logic [IDX_WIDTH-1:0]   checkCount_q, checkCount_d;
    logic [CNT_WIDTH-1:0]   failedCount_q, failedCount_d;
    logic                   mismatch_q, mismatch_d;
    logic [1:0]             mismatchKind_q, mismatchKind_d;

    logic                   capture;
    logic                   lastScore;
    logic                   expIsAnd;
    logic                   checkIsAnd;
    logic [WIDTH-1:0]       expOut;
    logic [1:0]             sampleKind;

    // Expected response of the registered sample; case-inequality makes X/Z responses fail.
    always_comb begin
        expIsAnd   = doAnd_q & ~doOr_q;
        checkIsAnd = ~(doAnd_q & doOr_q);
        case ({doAnd_q, doOr_q})
            2'b10:   expOut = aIn_q & bIn_q;
            2'b01:   expOut = aIn_q | bIn_q;
            default: expOut = '0;
        endcase
        if (checkIsAnd && (isAnd_q !== expIsAnd)) begin
            sampleKind = 2'b01;
        end else if (out_q !== expOut) begin
            sampleKind = 2'b10;
        end else begin
            sampleKind = 2'b00;
        end
    end

    assign lastScore = sampleValid_q &&
                       ((checkCount_q + IDX_WIDTH'(1)) == IDX_WIDTH'(NUM_CHECKS));

    always_comb begin
        state_d        = state_q;
        sampleValid_d  = 1'b0;
        capture        = 1'b0;
        checkCount_d   = checkCount_q;
        failedCount_d  = failedCount_q;
        mismatch_d     = 1'b0;
        mismatchKind_d = 2'b00;
        if (start) begin
            state_d       = RUN;
            checkCount_d  = '0;
            failedCount_d = '0;
        end else begin
            if (sampleValid_q) begin
                checkCount_d = checkCount_q + IDX_WIDTH'(1);
                if (sampleKind != 2'b00) begin
                    mismatch_d     = 1'b1;
                    mismatchKind_d = sampleKind;
                    if (failedCount_q != '1) begin
                        failedCount_d = failedCount_q + CNT_WIDTH'(1);
                    end
                end
                if (lastScore) begin
                    state_d = DONE;
                end
            end
            // A sample offered on the edge that closes the run is dropped.
            if ((state_q == RUN) && chkValid && !lastScore) begin
                sampleValid_d = 1'b1;
                capture       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sampleValid_q  <= 1'b0;
            checkCount_q   <= '0;
            failedCount_q  <= '0;
            mismatch_q     <= 1'b0;
            mismatchKind_q <= 2'b00;
        end else begin
            state_q        <= state_d;
            sampleValid_q  <= sampleValid_d;
            checkCount_q   <= checkCount_d;
            failedCount_q  <= failedCount_d;
            mismatch_q     <= mismatch_d;
            mismatchKind_q <= mismatchKind_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aIn_q   <= '0;
            bIn_q   <= '0;
            doAnd_q <= 1'b0;
            doOr_q  <= 1'b0;
            isAnd_q <= 1'b0;
            out_q   <= '0;
        end else if (capture) begin
            aIn_q   <= aIn;
            bIn_q   <= bIn;
            doAnd_q <= doAnd;
            doOr_q  <= doOr;
            isAnd_q <= isAnd;
            out_q   <= out;
        end
    end

    assign busy         = (state_q == RUN);
    assign done         = (state_q == DONE);
    assign pass         = (state_q == DONE) && (failedCount_q == '0);
    assign mismatch     = mismatch_q;
    assign mismatchKind = mismatchKind_q;
    assign failedCount  = failedCount_q;
    assign checkCount   = checkCount_q;

endmodule
